// File: rtl/ipg_pkg.sv
// Shared types and helpers for the per-port inter-packet-gap gate.
package ipg_pkg;

  typedef enum logic [1:0] {StHead, StBody, StGap} ipg_state_e;

  localparam int unsigned TuserDelayLsb = 32;
  localparam int unsigned TuserMaxW     = 1024;
  localparam int unsigned FieldMaxW     = 64;

  // Caller zero-extends tuser to TuserMaxW and truncates the result to its delay width.
  function automatic logic [FieldMaxW-1:0] tuser_field(input logic [TuserMaxW-1:0] tuser,
                                                       input int unsigned lsb);
    return FieldMaxW'(tuser >> lsb);
  endfunction

endpackage

// File: rtl/ipg_gap_counter.sv
// Down-counter for the idle gap: load, decrement to zero, and flag the final cycle.
module ipg_gap_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  input  logic             clear,
  output logic             done
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  // Last gap cycle: the counter reaches zero on this edge.
  assign done = (count_q == Width'(1));

endmodule

// File: rtl/per_port_ipg_gate.sv
// Pass-through AXI4-Stream gate that inserts a programmed idle gap after each packet.
module per_port_ipg_gate
  import ipg_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_DELAY_WIDTH        = 32,
  parameter int unsigned C_TUSER_DELAY_LSB    = TuserDelayLsb
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic                              sw_rst,
  input  logic                              enable,
  input  logic                              use_reg_delay,
  input  logic [C_DELAY_WIDTH-1:0]          delay_reg,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic                              gap_active,
  output logic [31:0]                       pkt_count
);

  ipg_state_e               state_q, state_d;
  logic                     gap_active_q;
  logic [31:0]              pkt_count_q;
  logic [C_DELAY_WIDTH-1:0] d_tuser_q;
  logic [C_DELAY_WIDTH-1:0] tuser_delay, delay_sel;
  logic                     rst, pass, hs, eop;
  logic                     cnt_load, cnt_dec, cnt_clear, cnt_done;

  assign rst  = ~axi_aresetn | sw_rst;
  assign pass = (state_q != StGap);
  assign hs   = s_axis_tvalid & m_axis_tready & pass;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tstrb  = s_axis_tstrb;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid & pass;
  assign s_axis_tready = m_axis_tready & pass;

  assign tuser_delay = C_DELAY_WIDTH'(tuser_field(TuserMaxW'(s_axis_tuser), C_TUSER_DELAY_LSB));
  // A single-beat packet ends in HEAD, so its own tuser field is used directly.
  assign delay_sel = use_reg_delay         ? delay_reg   :
                     (state_q == StHead)   ? tuser_delay : d_tuser_q;

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clear = 1'b0;
    eop       = 1'b0;
    unique case (state_q)
      StHead: begin
        if (hs) begin
          if (s_axis_tlast) eop = 1'b1;
          else              state_d = StBody;
        end
      end
      StBody: begin
        if (hs && s_axis_tlast) eop = 1'b1;
      end
      StGap: begin
        if (!enable) begin
          state_d   = StHead;
          cnt_clear = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_done) state_d = StHead;
        end
      end
      default: state_d = StHead;
    endcase
    if (eop) begin
      if (!enable || (delay_sel == '0)) begin
        state_d = StHead;
      end else begin
        state_d  = StGap;
        cnt_load = 1'b1;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state_q      <= StHead;
      gap_active_q <= 1'b0;
      pkt_count_q  <= '0;
      d_tuser_q    <= '0;
    end else begin
      state_q      <= state_d;
      gap_active_q <= (state_d == StGap);
      if (eop) pkt_count_q <= pkt_count_q + 32'd1;
      if (hs && (state_q == StHead)) d_tuser_q <= tuser_delay;
    end
  end

  ipg_gap_counter #(
    .Width (C_DELAY_WIDTH)
  ) u_gap_counter (
    .clk      (axi_aclk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (delay_sel),
    .dec      (cnt_dec),
    .clear    (cnt_clear),
    .done     (cnt_done)
  );

  assign gap_active = gap_active_q;
  assign pkt_count  = pkt_count_q;

endmodule
